// File: rtl/display_pkg.sv
// Shared glyph codes, segment patterns and requester ids
// for the 4-digit display arbiter.
package display_pkg;

  localparam logic [4:0] G_0 = 5'd0;
  localparam logic [4:0] G_1 = 5'd1;
  localparam logic [4:0] G_2 = 5'd2;
  localparam logic [4:0] G_3 = 5'd3;
  localparam logic [4:0] G_4 = 5'd4;
  localparam logic [4:0] G_5 = 5'd5;
  localparam logic [4:0] G_6 = 5'd6;
  localparam logic [4:0] G_7 = 5'd7;
  localparam logic [4:0] G_8 = 5'd8;
  localparam logic [4:0] G_9 = 5'd9;
  localparam logic [4:0] G_A = 5'd10;
  localparam logic [4:0] G_C = 5'd11;
  localparam logic [4:0] G_E = 5'd12;
  localparam logic [4:0] G_G = 5'd13;
  localparam logic [4:0] G_H = 5'd14;
  localparam logic [4:0] G_L = 5'd15;
  localparam logic [4:0] G_O = 5'd16;
  localparam logic [4:0] G_P = 5'd17;
  localparam logic [4:0] G_R = 5'd18;
  localparam logic [4:0] G_S = 5'd19;
  localparam logic [4:0] G_U = 5'd20;
  localparam logic [4:0] G_V = 5'd21;
  localparam logic [4:0] G_Y = 5'd22;
  localparam logic [4:0] G_BLANK = 5'd31;

  // {g,f,e,d,c,b,a}, a segment is lit when its bit is 0
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_G = 7'b1000010;
  localparam logic [6:0] SEG_H = 7'b0001001;
  localparam logic [6:0] SEG_L = 7'b1000111;
  localparam logic [6:0] SEG_O = 7'b1000000;
  localparam logic [6:0] SEG_P = 7'b0001100;
  localparam logic [6:0] SEG_R = 7'b0101111;
  localparam logic [6:0] SEG_S = 7'b0010010;
  localparam logic [6:0] SEG_U = 7'b1000001;
  localparam logic [6:0] SEG_V = 7'b1100011;
  localparam logic [6:0] SEG_Y = 7'b0010001;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [1:0] REQ_OVER = 2'd0;
  localparam logic [1:0] REQ_TURN = 2'd1;
  localparam logic [1:0] REQ_SCORE = 2'd2;

  typedef enum logic {
    IDLE,
    SHOW
  } arb_state_e;

  function automatic logic [1:0] lowest(input logic [2:0] r);
    if (r[0]) return REQ_OVER;
    if (r[1]) return REQ_TURN;
    return REQ_SCORE;
  endfunction

endpackage

// File: rtl/display_arbiter_glyph_decoder.sv
// Glyph code to active-low segment ROM.
// Undefined codes go dark.
module glyph_decoder
  import display_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (code)
      G_0: seg = SEG_0;
      G_1: seg = SEG_1;
      G_2: seg = SEG_2;
      G_3: seg = SEG_3;
      G_4: seg = SEG_4;
      G_5: seg = SEG_5;
      G_6: seg = SEG_6;
      G_7: seg = SEG_7;
      G_8: seg = SEG_8;
      G_9: seg = SEG_9;
      G_A: seg = SEG_A;
      G_C: seg = SEG_C;
      G_E: seg = SEG_E;
      G_G: seg = SEG_G;
      G_H: seg = SEG_H;
      G_L: seg = SEG_L;
      G_O: seg = SEG_O;
      G_P: seg = SEG_P;
      G_R: seg = SEG_R;
      G_S: seg = SEG_S;
      G_U: seg = SEG_U;
      G_V: seg = SEG_V;
      G_Y: seg = SEG_Y;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_arbiter.sv
// Shares the 4-digit display between three requesters,
// with hold-time arbitration, digit scanning and blinking.
module display_arbiter
  import display_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_TICKS = 1000,
  parameter int MIN_HOLD    = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [19:0] msg0,
  input  logic [19:0] msg1,
  input  logic [19:0] msg2,
  input  logic [2:0]  blink,
  output logic [2:0]  grant,
  output logic [3:0]  pos,
  output logic [6:0]  display
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int HW = $clog2(MIN_HOLD + 1);

  logic [PW-1:0] pcnt;
  logic          tick;
  logic [1:0]    scan;
  logic [BW-1:0] bcnt;
  logic          phase;

  arb_state_e    state, state_n;
  logic [1:0]    owner, owner_n;
  logic [HW-1:0] hold, hold_n;
  logic          load;
  logic [19:0]   snap, tgt_msg;
  logic          snap_blink, tgt_blink;
  logic [4:0]    code;
  logic [6:0]    seg;

  assign tick = (pcnt == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt  <= '0;
      scan  <= '0;
      bcnt  <= '0;
      phase <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) begin
        scan <= scan + 1'b1;
        if (bcnt == BW'(BLINK_TICKS - 1)) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  // At hold==0 the lowest requester either is the owner
  // (stay) or differs from it (switch, reload hold).
  always_comb begin
    state_n = state;
    owner_n = owner;
    hold_n  = hold;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_n = SHOW;
          owner_n = lowest(req);
          hold_n  = HW'(MIN_HOLD);
          load    = 1'b1;
        end
      end
      SHOW: begin
        if (hold != '0) begin
          if (tick) hold_n = hold - 1'b1;
          load = req[owner];
        end else if (|req) begin
          owner_n = lowest(req);
          load    = 1'b1;
          if (owner_n != owner) hold_n = HW'(MIN_HOLD);
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tgt_msg   = msg0;
    tgt_blink = blink[0];
    case (owner_n)
      REQ_TURN: begin
        tgt_msg   = msg1;
        tgt_blink = blink[1];
      end
      REQ_SCORE: begin
        tgt_msg   = msg2;
        tgt_blink = blink[2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= REQ_OVER;
      hold       <= '0;
      snap       <= '0;
      snap_blink <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      hold  <= hold_n;
      if (load) begin
        snap       <= tgt_msg;
        snap_blink <= tgt_blink;
      end
    end
  end

  assign grant = (state == SHOW) ? (3'b001 << owner) : 3'b000;

  always_comb begin
    code = snap[4:0];
    case (scan)
      2'd1: code = snap[9:5];
      2'd2: code = snap[14:10];
      2'd3: code = snap[19:15];
      default: ;
    endcase
  end

  glyph_decoder u_dec (
    .code (code),
    .seg  (seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos     <= 4'b1111;
      display <= SEG_OFF;
    end else begin
      pos <= ~(4'b0001 << scan);
      if (state == SHOW && !(snap_blink && phase))
        display <= seg;
      else
        display <= SEG_OFF;
    end
  end

endmodule
